multi_cycle_sequencer: RTL
==========================

Name: multi_cycle_sequencer

Overview:
- Moore-style FSM that sequences the shared single-ported datapath (register file, ALU, unified memory) over multiple cycles per instruction.
- Replaces single-cycle opcode decode for the multi-cycle build.
- Handles a memory ready handshake with a timeout.
- Drives the same control signal set consumed by the datapath: regWrite, memToReg, memRead, memWrite, regDst, aluOp, aluSrc, branch.

Parameters:
- MEM_TIMEOUT, 16: max cycles memRead/memWrite may stay asserted without memReady before faulting; legal range 1..255.
- TIMER_W, 8: width of the wait counter; must satisfy 2^TIMER_W > MEM_TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opCode  in  6  instruction register opcode field; sampled in DECODE
- registerEqual  in  1  rs==rt comparator result; sampled in BRANCH
- memReady  in  1  memory completes the current access this cycle
- pcWrite  out  1  PC load strobe
- irWrite  out  1  instruction register load strobe
- regWrite  out  1  register file write enable
- memToReg  out  1  writeback source: 1=memory, 0=ALU
- memRead  out  1  memory read request
- memWrite  out  1  memory write request
- regDst  out  1  destination select: 1=rd, 0=rt
- aluOp  out  2  00=add, 10=R-funct, 01=sub
- aluSrc  out  1  ALU B operand: 1=immediate, 0=register
- branch  out  1  branch taken strobe
- fault  out  1  sticky fault flag
- stateOut  out  3  current state encoding, for debug

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITE_BACK=5, BRANCH=6, FAULT=7.
- Reset (synchronous, active-high):
  - state=IDLE, latched opcode=0, wait counter=0, fault=0.
  - All outputs 0. No don't-care values are ever driven; unused controls are 0.
  - Reset overrides every state, including a pending memory wait; no memory strobe is asserted in the cycle after reset.
- IDLE: all outputs 0; go to FETCH unconditionally on the next cycle.
- FETCH:
  - memRead=1, aluSrc=0, aluOp=00 (PC+4 path).
  - On memReady=1: irWrite=1 and pcWrite=1 in that same cycle, then go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE: one cycle; latch opCode.
  - 000000 (R-type), 000001 (LW), 000010 (SW) -> EXECUTE.
  - 000011 (BEQ) -> BRANCH.
  - Any other opcode -> FAULT.
- EXECUTE: one cycle.
  - R-type: aluOp=10, aluSrc=0, then go to WRITE_BACK.
  - LW/SW: aluOp=00, aluSrc=1, then go to MEM.
- MEM:
  - LW drives memRead=1; SW drives memWrite=1; aluSrc=1 and aluOp=00 are held.
  - On memReady: LW goes to WRITE_BACK, SW goes to FETCH.
  - Otherwise stay in MEM and count.
- WRITE_BACK: one cycle; regWrite=1, then go to FETCH.
  - R-type: regDst=1, memToReg=0.
  - LW: regDst=0, memToReg=1.
- BRANCH: one cycle; aluOp=01, aluSrc=0, branch=registerEqual, pcWrite=registerEqual; then go to FETCH.
- Wait counter:
  - Cleared on entry to FETCH or MEM and on memReady.
  - While waiting, if counter==MEM_TIMEOUT-1 and memReady=0, go to FAULT on the next edge.
  - memReady arriving in that same final cycle wins: the access completes normally.
- FAULT: all outputs 0, fault=1; absorbing until reset.
- memReady outside FETCH/MEM is ignored.
- Latency with zero wait states: R=4 cycles, LW=5, SW=4, BEQ=3 (FETCH through the last state, inclusive). Each memory wait adds 1.
- All outputs are a pure decode of state + latched opcode, except branch/pcWrite in BRANCH and irWrite/pcWrite in FETCH, which also depend on registerEqual and memReady respectively.

Optional Feature:
- Macro: MULTI_CYCLE_SEQUENCER_PERF_EN.
- Defined:
  - Adds output retired[31:0] and output stallCycles[31:0].
  - retired: increments in the last cycle of each completed instruction (WRITE_BACK; SW MEM with memReady; BRANCH).
  - stallCycles: increments every cycle spent in FETCH or MEM with memReady=0.
  - Both counters clear on reset, wrap modulo 2^32, and freeze in FAULT.
- Undefined: neither port nor the counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - state encoding constants (3-bit);
  - opcode constants OP_RTYPE=000000, OP_LW=000001, OP_SW=000010, OP_BEQ=000011;
  - aluOp encodings ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10.
- One natural sub-module: mem_wait_timer.
  - Inputs: clear, enable, memReady.
  - Output: timeout.
  - Parameterised by MEM_TIMEOUT and TIMER_W.

Test Plan:
- Reset held 2 cycles, then released, with opCode=000000 and memReady tied 1 -> states IDLE, FETCH, DECODE, EXECUTE, WRITE_BACK, FETCH; regWrite=1 and regDst=1 only in WRITE_BACK.
- LW with memReady delayed 3 cycles in MEM -> memRead held 4 cycles; WRITE_BACK with memToReg=1, regDst=0; total 8 cycles.
- BEQ with registerEqual=1, then BEQ with registerEqual=0 -> first: branch=pcWrite=1 in BRANCH; second: both 0; 3 cycles each.
- opCode=111111 in DECODE -> FAULT next cycle; fault=1, all strobes 0, held until reset; reset returns to IDLE.
- MEM_TIMEOUT=4, memReady=0 in FETCH -> after 4 FETCH cycles enter FAULT; repeat with memReady on the 4th cycle -> DECODE, no fault.
- Reset asserted mid-MEM of SW with memReady=0 -> next cycle state=IDLE, memWrite=0, fault=0.

Source files
------------

// File: rtl/multi_cycle_sequencer_pkg.sv
// multi_cycle_sequencer_pkg: state, opcode and ALU-op encodings shared by the sequencer files
package multi_cycle_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH      = 3'd1,
        DECODE     = 3'd2,
        EXECUTE    = 3'd3,
        MEM        = 3'd4,
        WRITE_BACK = 3'd5,
        BRANCH     = 3'd6,
        FAULT      = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b000001;
    localparam logic [5:0] OP_SW    = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    function automatic logic is_exec_op(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_LW || op == OP_SW;
    endfunction

endpackage

// File: rtl/multi_cycle_sequencer_if.sv
// multi_cycle_sequencer_if: control and handshake bundle between the sequencer (master) and the datapath (slave)
interface multi_cycle_sequencer_if;
    logic [5:0] opCode;
    logic       registerEqual;
    logic       memReady;
    logic       pcWrite;
    logic       irWrite;
    logic       regWrite;
    logic       memToReg;
    logic       memRead;
    logic       memWrite;
    logic       regDst;
    logic [1:0] aluOp;
    logic       aluSrc;
    logic       branch;
    logic       fault;
    logic [2:0] stateOut;

    modport master (
        input  opCode, registerEqual, memReady,
        output pcWrite, irWrite, regWrite, memToReg, memRead, memWrite,
               regDst, aluOp, aluSrc, branch, fault, stateOut
    );

    modport slave (
        output opCode, registerEqual, memReady,
        input  pcWrite, irWrite, regWrite, memToReg, memRead, memWrite,
               regDst, aluOp, aluSrc, branch, fault, stateOut
    );
endinterface

// File: rtl/multi_cycle_sequencer_mem_wait_timer.sv
// mem_wait_timer: counts cycles a memory access waits for memReady and flags the final allowed cycle
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TIMER_W     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic memReady,
    output logic timeout
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear || memReady)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    // memReady in the last allowed cycle still completes the access
    assign timeout = enable && !memReady && count == TIMER_W'(MEM_TIMEOUT - 1);

endmodule

// File: rtl/multi_cycle_sequencer.sv
// multi_cycle_sequencer: Moore FSM sequencing a shared multi-cycle datapath with a memory-ready timeout.
// Define MULTI_CYCLE_SEQUENCER_PERF_EN to add retired/stallCycles performance counters.
module multi_cycle_sequencer
    import multi_cycle_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TIMER_W     = 8
) (
    input  logic clk,
    input  logic reset,
    multi_cycle_sequencer_if.master bus
`ifdef MULTI_CYCLE_SEQUENCER_PERF_EN
    ,
    output logic [31:0] retired,
    output logic [31:0] stallCycles
`endif
);

    state_t     state, next;
    logic [5:0] op_q;
    logic       waiting, timeout;

    assign waiting = state == FETCH || state == MEM;

    // Counter is held at zero outside the wait states, so each entry starts fresh
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TIMER_W(TIMER_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (!waiting),
        .enable   (waiting),
        .memReady (bus.memReady),
        .timeout  (timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= '0;
        end else begin
            state <= next;
            if (state == DECODE)
                op_q <= bus.opCode;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:       next = FETCH;
            FETCH:      next = bus.memReady ? DECODE : timeout ? FAULT : FETCH;
            DECODE:     next = is_exec_op(bus.opCode) ? EXECUTE : bus.opCode == OP_BEQ ? BRANCH : FAULT;
            EXECUTE:    next = op_q == OP_RTYPE ? WRITE_BACK : MEM;
            MEM:        next = bus.memReady ? (op_q == OP_LW ? WRITE_BACK : FETCH) : timeout ? FAULT : MEM;
            WRITE_BACK: next = FETCH;
            BRANCH:     next = FETCH;
            default:    next = FAULT;
        endcase
    end

    assign bus.irWrite  = state == FETCH && bus.memReady;
    assign bus.branch   = state == BRANCH && bus.registerEqual;
    assign bus.pcWrite  = bus.irWrite || bus.branch;
    assign bus.memRead  = state == FETCH || (state == MEM && op_q == OP_LW);
    assign bus.memWrite = state == MEM && op_q == OP_SW;
    assign bus.regWrite = state == WRITE_BACK;
    assign bus.regDst   = state == WRITE_BACK && op_q == OP_RTYPE;
    assign bus.memToReg = state == WRITE_BACK && op_q == OP_LW;
    assign bus.aluOp    = (state == EXECUTE && op_q == OP_RTYPE) ? ALU_FUNCT :
                          state == BRANCH ? ALU_SUB : ALU_ADD;
    assign bus.aluSrc   = (state == EXECUTE && op_q != OP_RTYPE) || state == MEM;
    assign bus.fault    = state == FAULT;
    assign bus.stateOut = state;

`ifdef MULTI_CYCLE_SEQUENCER_PERF_EN
    logic done;

    assign done = state == WRITE_BACK || state == BRANCH ||
                  (state == MEM && op_q == OP_SW && bus.memReady);

    always_ff @(posedge clk) begin
        if (reset) begin
            retired     <= '0;
            stallCycles <= '0;
        end else if (state != FAULT) begin
            retired     <= retired + 32'(done);
            stallCycles <= stallCycles + 32'(waiting && !bus.memReady);
        end
    end
`endif

endmodule
